// File: rtl/event_stat_register_bank.sv
// Event statistics register bank: per-channel saturating event counters with snapshots,
// sticky error flags and a run-gated channel mask behind a Wishbone target port.
// Optional feature macro: EVENT_STAT_CLEAR_ON_SNAPSHOT_EN (snapshot also restarts the live counters).
module event_stat_register_bank #(
   parameter int                NUM_CH     = 4,
   parameter int                CNT_WIDTH  = 32,
   parameter logic [NUM_CH-1:0] MASK_RESET = '1
) (
   input  logic              wb_clk_i,
   input  logic              rst_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [12:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic [3:0]        wb_sel_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              wb_rty_o,
   input  logic [NUM_CH-1:0] ch_valid_i,
   input  logic [31:0]       err_i,
   input  logic              running_i,
   output logic [NUM_CH-1:0] ch_mask_o,
   output logic              force_reset_o
);

   // Handshake: a request is cyc&&stb; ack follows one cycle later and is qualified by the
   // live request, so a write commits on the edge that ends the acked cycle and read data
   // is captured on the first request cycle, before ack rises.
   logic                 ack_q;
   logic [31:0]          dat_q;
   logic                 force_q, force_d;
   logic                 freeze_q, freeze_d;
   logic [NUM_CH-1:0]    mask_next_q, mask_next_d;
   logic [NUM_CH-1:0]    mask_q;
   logic [31:0]          err_q, err_d;
   logic                 run_q;
   logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
   logic [CNT_WIDTH-1:0] snap_q [NUM_CH];
   logic [CNT_WIDTH-1:0] snap_d [NUM_CH];

   logic                 req, wr;
   logic [5:0]           word;
   logic [31:0]          be;
   logic                 wr_ctrl, snap_pulse;
   logic [NUM_CH-1:0]    inc;
   logic [31:0]          rd_data;
   logic                 unused_adr;

   assign req        = wb_cyc_i && wb_stb_i;
   assign wb_ack_o   = ack_q && req;
   assign wr         = wb_ack_o && wb_we_i;
   assign word       = wb_adr_i[7:2];
   assign be         = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wr_ctrl    = wr && (word == 6'd0) && wb_sel_i[0];
   assign snap_pulse = wr_ctrl && wb_dat_i[1];
   assign inc        = ch_valid_i & mask_q & {NUM_CH{~freeze_q & ~force_q}};
   assign unused_adr = ^{wb_adr_i[12:8], wb_adr_i[1:0]};

   assign wb_dat_o      = dat_q;
   assign wb_err_o      = 1'b0;
   assign wb_rty_o      = 1'b0;
   assign ch_mask_o     = mask_q;
   assign force_reset_o = force_q;

   always_comb begin
      force_d     = force_q;
      freeze_d    = freeze_q;
      mask_next_d = mask_next_q;
      err_d       = err_q | err_i;
      if (wr_ctrl) begin
         force_d  = wb_dat_i[0];
         freeze_d = wb_dat_i[2];
      end
      if (wr && (word == 6'd1))
         mask_next_d = (mask_next_q & ~be[NUM_CH-1:0]) | (wb_dat_i[NUM_CH-1:0] & be[NUM_CH-1:0]);
      // Clear is applied before OR-ing in err_i so a same-cycle set wins.
      if (wr && (word == 6'd2))
         err_d = (err_q & ~(wb_dat_i & be)) | err_i;
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]  = cnt_q[i];
         snap_d[i] = snap_q[i];
         if (inc[i] && !(&cnt_q[i]))
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         if (snap_pulse) begin
            snap_d[i] = cnt_q[i];
`ifdef EVENT_STAT_CLEAR_ON_SNAPSHOT_EN
            cnt_d[i] = inc[i] ? CNT_WIDTH'(1) : '0;
`else
            cnt_d[i] = cnt_d[i];
`endif
         end
         if (force_q) begin
            cnt_d[i]  = '0;
            snap_d[i] = '0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (word)
         6'd0: rd_data[2:0] = {freeze_q, 1'b0, force_q};
         6'd1: begin
            rd_data[16 +: NUM_CH] = mask_q;
            rd_data[NUM_CH-1:0]   = mask_next_q;
         end
         6'd2: rd_data = err_q;
         6'd3: begin
            rd_data[0]     = running_i;
            rd_data[12:8]  = 5'(NUM_CH);
            rd_data[21:16] = 6'(CNT_WIDTH);
         end
         default: begin
            for (int i = 0; i < NUM_CH; i++)
               if (word == 6'(16 + i)) rd_data[CNT_WIDTH-1:0] = snap_q[i];
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q       <= 1'b0;
         dat_q       <= '0;
         force_q     <= 1'b0;
         freeze_q    <= 1'b0;
         mask_next_q <= MASK_RESET;
         mask_q      <= MASK_RESET;
         err_q       <= '0;
         run_q       <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         ack_q       <= req;
         force_q     <= force_d;
         freeze_q    <= freeze_d;
         mask_next_q <= mask_next_d;
         err_q       <= err_d;
         run_q       <= running_i;
         if (req && !ack_q) dat_q <= rd_data;
         // The active mask only moves on a 0->1 transition of running_i.
         if (running_i && !run_q) mask_q <= mask_next_q;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            snap_q[i] <= snap_d[i];
         end
      end
   end

endmodule
